data_cache: RTL
===============

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 SHALL have port rd_en  input  1  CPU load request.
REQ-005 SHALL have port wr_en  input  1  CPU store request.
REQ-006 SHALL have port ByteAddress  input  1  byte-sized access when high, word-sized when low.
REQ-007 SHALL have port addr  input  `WORD_SIZE  byte address: [3:2] word offset, [3+log2(NUM_LINES):4] index, upper bits tag.
REQ-008 SHALL have port wdata  input  `WORD_SIZE  store data.
REQ-009 SHALL have port rdata  output  `WORD_SIZE  load data, valid when rd_en and stall low.
REQ-010 SHALL have port stall  output  1  CPU must hold its request while high.
REQ-011 SHALL have port mem_read  output  1  line-fill request to dataMemory Read.
REQ-012 SHALL have port mem_ready  input  1  dataMemory Ready.
REQ-013 SHALL have port mem_line  input  `CACHE_LINE_SIZE  fill data, word 0 in bits [31:0].
REQ-014 SHALL have port mem_we, mem_byte, mem_addr, mem_wdata  output  1/1/`WORD_SIZE/`WORD_SIZE  store path to dataMemory WE/ByteAddress/A/WD.
REQ-015 SHALL have port miss_count  output  16  saturating count of load misses.

Function
REQ-016 SHALL implement FSM states IDLE, MISS, DONE.
REQ-017 IDLE, load hit (valid and tag match): rdata combinational same cycle, stall low, no state change.
REQ-018 Word load SHALL return the selected word; byte load SHALL return bits [31:24] of it sign-extended to 32 bits.
REQ-019 IDLE, load miss: stall high same cycle; next state MISS; miss address latched; miss_count increments unless 16'hFFFF.
REQ-020 MISS: mem_read held high, mem_addr = {latched addr[31:4], 4'b0}, stall high, until mem_ready sampled high.
REQ-021 Cycle mem_ready sampled high in MISS: line data <= mem_line, tag written, valid set; next state DONE.
REQ-022 DONE: mem_read low, stall high; next state IDLE, where the held load hits (one mandatory Read-low cycle restarts the memory pipeline).
REQ-023 Miss latency with a 5-cycle memory: stall high for 7 cycles from the request cycle (1 IDLE + 5 MISS + 1 DONE).
REQ-024 Stores: write-through, no-write-allocate; in IDLE mem_we = wr_en, mem_addr = addr, mem_wdata = wdata, mem_byte = ByteAddress, stall low.
REQ-025 Store hit SHALL update the cached word (byte store: bits [31:24] <= wdata[7:0]) on the same edge; store miss leaves cache unchanged.
REQ-026 rd_en and wr_en both high SHALL be treated as a store only.
REQ-027 mem_we SHALL be low outside IDLE; rd_en/wr_en are ignored in MISS and DONE.
REQ-028 mem_read SHALL be low in IDLE and DONE.

Reset
REQ-029 rst SHALL force state IDLE, clear all valid bits and miss_count; stall, mem_read, mem_we low after the edge.
REQ-030 rst during MISS SHALL abort the fill: mem_read low next cycle, no line written.
REQ-031 Line data and tags need not be reset.

Verification
REQ-032 After reset, load word 0x40 (mem[0x40..]=line) -> stall 7 cycles, mem_read high 5 cycles, then rdata = word, miss_count=1.
REQ-033 Repeat load 0x44 same line -> zero stall, rdata = word 1 of line, miss_count unchanged.
REQ-034 Store 0xDEADBEEF to 0x48 (hit) -> mem_we one cycle, next load 0x48 returns 0xDEADBEEF without stall.
REQ-035 Byte store 0x80 to 0x40 then byte load 0x40 -> rdata = 0xFFFFFF80.
REQ-036 Two loads 0x40 and 0x40+16*NUM_LINES alternating -> each misses, miss_count increments per load, mem_read low >=1 cycle between fills.
REQ-037 rst asserted 2 cycles into MISS -> mem_read low next cycle, subsequent load to same address misses again.

Source files
------------

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped, write-through, no-write-allocate data cache
// Load misses fill a whole 4-word line from dataMemory; stores always go straight through.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

module data_cache #(
    parameter int NUM_LINES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic                        wr_en,
    input  logic                        ByteAddress,
    input  logic [`WORD_SIZE-1:0]       addr,
    input  logic [`WORD_SIZE-1:0]       wdata,
    output logic [`WORD_SIZE-1:0]       rdata,
    output logic                        stall,
    output logic                        mem_read,
    input  logic                        mem_ready,
    input  logic [`CACHE_LINE_SIZE-1:0] mem_line,
    output logic                        mem_we,
    output logic                        mem_byte,
    output logic [`WORD_SIZE-1:0]       mem_addr,
    output logic [`WORD_SIZE-1:0]       mem_wdata,
    output logic [15:0]                 miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, MISS, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES][4];
    logic [27:0]          r_miss_line;
    logic [15:0]          r_miss_count;

    logic [IDX_W-1:0] w_index;
    logic [TAG_W-1:0] w_tag;
    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_miss_index;
    logic [TAG_W-1:0] w_miss_tag;
    logic             w_hit;
    logic             w_load;
    logic             w_load_miss;
    logic             w_store_hit;
    logic             w_fill;
    logic [31:0]      w_word;
    logic             w_unused_addr;

    assign w_index       = addr[4 +: IDX_W];
    assign w_tag         = addr[31 -: TAG_W];
    assign w_off         = addr[3:2];
    assign w_miss_index  = r_miss_line[0 +: IDX_W];
    assign w_miss_tag    = r_miss_line[27 -: TAG_W];
    assign w_unused_addr = &{1'b0, addr[1:0]};

    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // a simultaneous load+store request is treated purely as a store
    assign w_load      = rd_en && !wr_en;
    assign w_load_miss = (r_state == IDLE) && w_load && !w_hit;
    assign w_store_hit = (r_state == IDLE) && wr_en && w_hit;
    assign w_fill      = (r_state == MISS) && mem_ready;

    assign w_word     = r_data[w_index][w_off];
    assign rdata      = ByteAddress ? {{24{w_word[31]}}, w_word[31:24]} : w_word;
    assign miss_count = r_miss_count;

    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        mem_read  = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = addr;
        mem_wdata = wdata;
        case (r_state)
            IDLE: begin
                mem_we   = wr_en;
                mem_byte = ByteAddress;
                if (w_load && !w_hit) begin
                    stall  = 1'b1;
                    w_next = MISS;
                end
            end
            MISS: begin
                mem_read = 1'b1;
                stall    = 1'b1;
                mem_addr = {r_miss_line, 4'b0000};
                if (mem_ready) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                // Read must drop for a cycle before memory accepts another request
                stall    = 1'b1;
                mem_addr = {r_miss_line, 4'b0000};
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_load_miss && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
            if (w_fill) begin
                r_valid[w_miss_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_load_miss) begin
                r_miss_line <= addr[31:4];
            end
            if (w_fill) begin
                r_tag[w_miss_index] <= w_miss_tag;
                for (int w = 0; w < 4; w++) begin
                    r_data[w_miss_index][w] <= mem_line[w*32 +: 32];
                end
            end
            if (w_store_hit) begin
                if (ByteAddress) begin
                    r_data[w_index][w_off][31:24] <= wdata[7:0];
                end else begin
                    r_data[w_index][w_off] <= wdata;
                end
            end
        end
    end

endmodule
